// File: rtl/stack_node_pkg.sv
// rtl/stack_node_pkg.sv - shared node-grid constants and FSM state encoding
package stack_node_pkg;
    localparam int NUM_PORTS = 4;
    localparam int DEF_DW    = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } node_state_e;
endpackage

// File: rtl/stack_node_if.sv
// rtl/stack_node_if.sv - four-port node-to-node write/read bundle
interface stack_node_if #(
    parameter int DW = stack_node_pkg::DEF_DW
) ();
    import stack_node_pkg::*;

    logic [NUM_PORTS-1:0][DW-1:0] wdata;
    logic [NUM_PORTS-1:0]         wval;
    logic [NUM_PORTS-1:0]         wresp;
    logic [NUM_PORTS-1:0][DW-1:0] rdata;
    logic [NUM_PORTS-1:0]         rrdy;
    logic [NUM_PORTS-1:0]         rresp;

    // slave: the storage node; master: the neighbouring compute nodes
    modport slave  (input wdata, wval, rresp, output wresp, rdata, rrdy);
    modport master (output wdata, wval, rresp, input wresp, rdata, rrdy);
endinterface

// File: rtl/stack_node_rr_arb4.sv
// rtl/stack_node_rr_arb4.sv - 4-request round-robin arbiter, search starts at ptr_i
module rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic       valid_o
);
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_i + 2'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;
endmodule

// File: rtl/stack_node.sv
// rtl/stack_node.sv - four-port LIFO node sitting in the grid in place of a compute tile
module stack_node
    import stack_node_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 15,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    stack_node_if.slave   port_if,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    node_state_e          state_q, state_d;
    logic [DW-1:0]        mem_q [DEPTH];
    logic [CW-1:0]        sp_q;
    logic [1:0]           optr_q;
    logic [1:0]           wptr_q;
    logic [NUM_PORTS-1:0] wresp_q;

    logic [NUM_PORTS-1:0] rrdy;
    logic [NUM_PORTS-1:0] gnt;
    logic                 gnt_valid;
    logic [1:0]           gnt_idx;
    logic [DW-1:0]        wsel;
    logic [DW-1:0]        top;
    logic                 pop, push;

    assign empty_o = (sp_q == '0);
    assign full_o  = (sp_q == CW'(DEPTH));
    assign count_o = sp_q;

    rr_arb4 u_arb (
        .req_i   (port_if.wval),
        .ptr_i   (wptr_q),
        .gnt_o   (gnt),
        .valid_o (gnt_valid)
    );

    always_comb begin
        gnt_idx = '0;
        wsel    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt[k]) begin
                gnt_idx = 2'(k);
                wsel    = port_if.wdata[k];
            end
        end
    end

    // rrdy is only ever offered in IDLE, so a consume here implies IDLE
    assign pop  = |(rrdy & port_if.rresp);
    assign push = (state_q == ST_IDLE) && !pop && !full_o && gnt_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pop || push) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        top  = empty_o ? '0 : mem_q[sp_q - CW'(1)];
        rrdy = '0;
        if (state_q == ST_IDLE && !empty_o) rrdy[optr_q] = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++) port_if.rdata[k] = top;
        port_if.rrdy  = rrdy;
        port_if.wresp = wresp_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp_q    <= '0;
            optr_q  <= '0;
            wptr_q  <= '0;
            wresp_q <= '0;
        end else begin
            optr_q  <= optr_q + 2'd1;
            wresp_q <= push ? gnt : '0;
            if (pop) begin
                sp_q <= sp_q - CW'(1);
            end else if (push) begin
                sp_q   <= sp_q + CW'(1);
                wptr_q <= gnt_idx + 2'd1;
            end
        end
    end

    // storage is not reset; contents past sp are never observed
    always_ff @(posedge clk_i) begin
        if (push) mem_q[sp_q] <= wsel;
    end
endmodule

// File: tb/tb_stack_node.sv
// tb/tb_stack_node.sv - directed scoreboard bench for stack_node
module tb_stack_node;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count;
    logic       full, empty;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    stack_node_if #(.DW(8)) bus ();

    stack_node #(.DW(8), .DEPTH(15)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .port_if (bus),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        bus.wval  = '0;
        bus.rresp = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_word(input int port, input logic [7:0] d);
        int lat = -1;
        bus.wdata[port] = d;
        bus.wval[port]  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.wresp[port]) begin
                lat = c;
                break;
            end
        end
        bus.wval[port] = 1'b0;
        check("push_ack", 32'(lat >= 0), 32'd1);
        exp_q.push_front(d);
    endtask

    task automatic pop_n(input int port, input int n);
        int got = 0;
        logic [7:0] expv;
        bus.rresp[port] = 1'b1;
        for (int c = 0; c < 200 && got < n; c++) begin
            if (bus.rrdy[port]) begin
                expv = exp_q.pop_front();
                check("pop_data", 32'(bus.rdata[port]), 32'(expv));
                got++;
            end
            step();
        end
        bus.rresp[port] = 1'b0;
        check("pop_done", 32'(got), 32'(n));
    endtask

    initial begin
        int lat;
        logic [3:0] seen;
        int order[$];
        int tstamp[$];
        bus.wdata = '0;
        bus.wval  = '0;
        bus.rresp = '0;

        // reset state, then single push from port 0
        do_reset();
        check("rst_wresp", 32'(bus.wresp), 32'h0);
        check("rst_rrdy",  32'(bus.rrdy), 32'h0);
        check("rst_rdata", 32'(bus.rdata[0]), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        bus.wdata[0] = 8'h12;
        bus.wval[0]  = 1'b1;
        step();
        check("p1_wresp", 32'(bus.wresp), 32'h1);
        check("p1_count", 32'(count), 32'd1);
        for (int k = 0; k < 4; k++) check("p1_rdata", 32'(bus.rdata[k]), 32'h12);
        check("p1_rrdy_settle", 32'(bus.rrdy), 32'h0);
        bus.wval[0] = 1'b0;
        step();
        check("p1_wresp_off", 32'(bus.wresp), 32'h0);
        check("p1_rrdy_offer", 32'(bus.rrdy), 32'h4);

        // LIFO order through port 1 / port 2
        do_reset();
        push_word(1, 8'h01);
        push_word(1, 8'h02);
        push_word(1, 8'h03);
        pop_n(2, 3);
        check("lifo_empty", 32'(empty), 32'd1);
        bus.rresp[2] = 1'b1;
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            seen |= bus.rrdy;
            step();
        end
        bus.rresp[2] = 1'b0;
        check("empty_no_rrdy", 32'(seen), 32'h0);

        // full stalls the writer until a pop frees a slot
        do_reset();
        for (int i = 0; i < 15; i++) push_word(0, 8'(8'h20 + i));
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd15);
        bus.wdata[3] = 8'h55;
        bus.wval[3]  = 1'b1;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen |= bus.wresp;
        end
        check("full_no_wresp", 32'(seen), 32'h0);
        pop_n(0, 1);
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            if (bus.wresp[3]) begin
                lat = c;
                break;
            end
            step();
        end
        check("full_resume_lat", 32'(lat), 32'd2);
        check("full_resume_top", 32'(bus.rdata[1]), 32'h55);
        check("full_resume_cnt", 32'(count), 32'd15);
        bus.wval[3] = 1'b0;

        // round-robin acceptance with all writers pending
        do_reset();
        for (int k = 0; k < 4; k++) bus.wdata[k] = 8'(8'hA0 + k);
        bus.wval = 4'hF;
        for (int k = 0; k < 4; k++) exp_q.push_front(8'(8'hA0 + k));
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (bus.wresp[k]) begin
                    order.push_back(k);
                    tstamp.push_back(c);
                    bus.wval[k] = 1'b0;
                end
            end
        end
        check("rr_accepts", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i));
            for (int i = 1; i < 4; i++) check("rr_spacing", 32'(tstamp[i] - tstamp[i-1]), 32'd2);
        end
        pop_n(1, 1);

        // pop beats a simultaneous push request
        do_reset();
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        bus.rresp[1] = 1'b1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (bus.rrdy[1]) begin
                lat = c;
                break;
            end
            step();
        end
        check("prio_offer", 32'(lat >= 0), 32'd1);
        bus.wdata[2] = 8'h33;
        bus.wval[2]  = 1'b1;
        check("prio_pop_data", 32'(bus.rdata[1]), 32'(exp_q.pop_front()));
        step();
        bus.rresp[1] = 1'b0;
        check("prio_count", 32'(count), 32'd1);
        check("prio_no_wresp", 32'(bus.wresp), 32'h0);
        check("prio_top", 32'(bus.rdata[2]), 32'h11);
        step();
        check("prio_no_wresp2", 32'(bus.wresp), 32'h0);
        step();
        check("prio_late_wresp", 32'(bus.wresp), 32'h4);
        check("prio_late_count", 32'(count), 32'd2);
        check("prio_late_top", 32'(bus.rdata[0]), 32'h33);
        bus.wval[2] = 1'b0;

        // reset during the settle cycle after a push
        do_reset();
        bus.wdata[0] = 8'h77;
        bus.wval[0]  = 1'b1;
        step();
        check("mid_wresp", 32'(bus.wresp), 32'h1);
        rst = 1'b1;
        bus.wval[0] = 1'b0;
        step();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_wresp", 32'(bus.wresp), 32'h0);
        check("mid_rst_rrdy",  32'(bus.rrdy), 32'h0);
        check("mid_rst_rdata", 32'(bus.rdata[3]), 32'h0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
